note_hit_judge: RTL and testbench

NOTE_HIT_JUDGE -- requirements
Module: note_hit_judge

---
 rtl/note_hit_judge_pkg.sv | 28 ++
 rtl/note_hit_judge_if.sv | 23 ++
 rtl/key_sync_edge.sv | 29 ++
 rtl/note_hit_judge.sv | 110 +++++++++++
 tb/tb_note_hit_judge.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/note_hit_judge_pkg.sv
// Shared types and constants for the guitar lane hit judge: judgement codes,
// judge FSM states, point values and a saturating score adder.
package guitar_pkg;

  typedef enum logic [1:0] {
    JUDGE_NONE    = 2'd0,
    JUDGE_PERFECT = 2'd1,
    JUDGE_GOOD    = 2'd2,
    JUDGE_MISS    = 2'd3
  } judge_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_JUDGED = 2'd2
  } state_t;

  localparam logic [15:0] PTS_PERFECT = 16'd100;
  localparam logic [15:0] PTS_GOOD    = 16'd50;
  localparam logic [7:0]  COMBO_BONUS = 8'd10;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/note_hit_judge_if.sv
// Lane bundle between the note renderer/key input (master) and the hit judge (slave).
import guitar_pkg::*;

interface note_hit_judge_if;
  logic        note_active;
  logic [9:0]  note_y_pos;
  logic        key_press;
  logic        hit_pulse;
  logic        miss_pulse;
  judge_t      judge;
  logic [15:0] score;
  logic [7:0]  combo;

  modport master (
    output note_active, note_y_pos, key_press,
    input  hit_pulse, miss_pulse, judge, score, combo
  );

  modport slave (
    input  note_active, note_y_pos, key_press,
    output hit_pulse, miss_pulse, judge, score, combo
  );
endinterface

// File: rtl/key_sync_edge.sv
// Two-flop synchronizer for an asynchronous key level followed by a rising-edge
// detector; one instance per lane.
module key_sync_edge (
  input  logic Clk,
  input  logic Reset_n,
  input  logic i_async,
  output logic o_rise
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= i_async;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign o_rise = r_sync2 & ~r_prev;

endmodule

// File: rtl/note_hit_judge.sv
// Judges one lane: arms on a visible note, grades the first key edge by the
// note-center distance to the strum line, and tracks score and combo.
import guitar_pkg::*;

module note_hit_judge #(
  parameter logic [9:0] HIT_LINE_Y  = 10'd400,
  parameter logic [9:0] NOTE_SIZE   = 10'd40,
  parameter logic [9:0] WIN_PERFECT = 10'd8,
  parameter logic [9:0] WIN_GOOD    = 10'd24
) (
  input  logic             Clk,
  input  logic             Reset_n,
  note_hit_judge_if.slave  bus
);

  localparam logic [10:0] HALF_SIZE  = {2'b00, NOTE_SIZE[9:1]};
  localparam logic [10:0] LINE_Y     = {1'b0, HIT_LINE_Y};
  localparam logic [10:0] LATE_LIMIT = LINE_Y + {1'b0, WIN_GOOD};

  logic        w_key_rise;
  logic [10:0] w_center;
  logic [10:0] w_distance;
  logic        w_miss;
  logic        w_in_perfect;
  logic        w_in_good;
  logic [15:0] w_points;

  state_t      r_state,      w_state_nxt;
  judge_t      r_judge,      w_judge_nxt;
  logic [15:0] r_score,      w_score_nxt;
  logic [7:0]  r_combo,      w_combo_nxt;
  logic        r_hit_pulse,  w_hit_nxt;
  logic        r_miss_pulse, w_miss_nxt;

  key_sync_edge u_key_sync (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .i_async (bus.key_press),
    .o_rise  (w_key_rise)
  );

  // 11-bit arithmetic so a note near the bottom of the screen cannot wrap.
  assign w_center     = {1'b0, bus.note_y_pos} + HALF_SIZE;
  assign w_distance   = (w_center >= LINE_Y) ? (w_center - LINE_Y) : (LINE_Y - w_center);
  assign w_miss       = !bus.note_active || (w_center > LATE_LIMIT);
  assign w_in_perfect = (w_distance <= {1'b0, WIN_PERFECT});
  assign w_in_good    = (w_distance <= {1'b0, WIN_GOOD});
  assign w_points     = (r_combo >= COMBO_BONUS) ? ((w_in_perfect ? PTS_PERFECT : PTS_GOOD) << 1)
                                                 :  (w_in_perfect ? PTS_PERFECT : PTS_GOOD);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state      <= ST_IDLE;
      r_judge      <= JUDGE_NONE;
      r_score      <= '0;
      r_combo      <= '0;
      r_hit_pulse  <= 1'b0;
      r_miss_pulse <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_judge      <= w_judge_nxt;
      r_score      <= w_score_nxt;
      r_combo      <= w_combo_nxt;
      r_hit_pulse  <= w_hit_nxt;
      r_miss_pulse <= w_miss_nxt;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    w_state_nxt = r_state;
    w_judge_nxt = r_judge;
    w_score_nxt = r_score;
    w_combo_nxt = r_combo;
    w_hit_nxt   = 1'b0;
    w_miss_nxt  = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (bus.note_active) w_state_nxt = ST_ARMED;
      end
      ST_ARMED: begin
        // A miss outranks a simultaneous key edge; out-of-window edges are dropped silently.
        if (w_miss) begin
          w_judge_nxt = JUDGE_MISS;
          w_combo_nxt = '0;
          w_miss_nxt  = 1'b1;
          w_state_nxt = ST_JUDGED;
        end else if (w_key_rise && w_in_good) begin
          w_judge_nxt = w_in_perfect ? JUDGE_PERFECT : JUDGE_GOOD;
          w_score_nxt = sat_add16(r_score, w_points);
          w_combo_nxt = (r_combo == 8'hFF) ? r_combo : r_combo + 8'd1;
          w_hit_nxt   = 1'b1;
          w_state_nxt = ST_JUDGED;
        end
      end
      ST_JUDGED: begin
        if (!bus.note_active) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign bus.hit_pulse  = r_hit_pulse;
  assign bus.miss_pulse = r_miss_pulse;
  assign bus.judge      = r_judge;
  assign bus.score      = r_score;
  assign bus.combo      = r_combo;

endmodule

// File: tb/tb_note_hit_judge.sv
// Directed bench for note_hit_judge: latency, windows, combo bonus, saturation,
// held-key behaviour and asynchronous reset.
import guitar_pkg::*;

module tb_note_hit_judge;

  logic Clk = 1'b0;
  logic Reset_n;
  always #10 Clk = ~Clk;

  note_hit_judge_if bus_if ();

  note_hit_judge dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus_if)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int hit_cnt  = 0;
  int miss_cnt = 0;

  always @(posedge Clk) begin
    #2;
    if (bus_if.hit_pulse)  hit_cnt++;
    if (bus_if.miss_pulse) miss_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // One-cycle key pulse; reports the negedge index (edges elapsed) of the first hit_pulse.
  task automatic key_pulse(output int hit_at);
    hit_at = -1;
    bus_if.key_press = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge Clk);
      if (i == 1) bus_if.key_press = 1'b0;
      if (bus_if.hit_pulse && hit_at < 0) hit_at = i;
    end
  endtask

  task automatic new_note(input logic [9:0] y);
    bus_if.note_active = 1'b0;
    cycles(2);
    bus_if.note_y_pos  = y;
    bus_if.note_active = 1'b1;
    cycles(2);
  endtask

  // Falls the note by 3 px per cycle up to 407; returns the y at which miss_pulse was first seen.
  task automatic ramp_to_miss(input int y0, output int miss_y);
    int y;
    miss_y = -1;
    y = y0;
    forever begin
      bus_if.note_y_pos = 10'(y);
      @(negedge Clk);
      if (bus_if.miss_pulse && miss_y < 0) miss_y = y;
      if (y == 407) break;
      y = (y + 3 > 407) ? 407 : y + 3;
    end
    cycles(2);
  endtask

  initial begin
    int h;
    int my;
    int hits0;
    int miss0;

    bus_if.note_active = 1'b0;
    bus_if.note_y_pos  = '0;
    bus_if.key_press   = 1'b0;
    Reset_n = 1'b0;
    #5;
    check("rst_judge", bus_if.judge, JUDGE_NONE);
    check("rst_score", bus_if.score, 0);
    check("rst_combo", bus_if.combo, 0);
    check("rst_hit",   bus_if.hit_pulse, 0);
    check("rst_miss",  bus_if.miss_pulse, 0);
    cycles(2);
    Reset_n = 1'b1;
    cycles(1);

    // PERFECT at center 400, with pulse latency
    new_note(10'd380);
    key_pulse(h);
    check("perfect_latency", h, 3);
    check("perfect_hits",    hit_cnt, 1);
    check("perfect_judge",   bus_if.judge, JUDGE_PERFECT);
    check("perfect_score",   bus_if.score, 100);
    check("perfect_combo",   bus_if.combo, 1);
    check("perfect_nomiss",  miss_cnt, 0);

    // GOOD at distance 20
    new_note(10'd400);
    key_pulse(h);
    check("good_hits",  hit_cnt, 2);
    check("good_judge", bus_if.judge, JUDGE_GOOD);
    check("good_score", bus_if.score, 150);
    check("good_combo", bus_if.combo, 2);

    // Asynchronous reset while ARMED, between clock edges
    new_note(10'd300);
    #3;
    Reset_n = 1'b0;
    #2;
    check("async_rst_score", bus_if.score, 0);
    check("async_rst_combo", bus_if.combo, 0);
    check("async_rst_judge", bus_if.judge, JUDGE_NONE);
    @(negedge Clk);
    Reset_n = 1'b1;

    // Early key edge ignored, then the re-armed note falls past the window
    key_pulse(h);
    check("early_key_nohit", h, -1);
    check("early_key_judge", bus_if.judge, JUDGE_NONE);
    check("early_key_score", bus_if.score, 0);
    miss0 = miss_cnt;
    ramp_to_miss(300, my);
    check("late_miss_y",     my, 405);
    check("late_miss_count", miss_cnt - miss0, 1);
    check("late_miss_judge", bus_if.judge, JUDGE_MISS);
    check("late_miss_combo", bus_if.combo, 0);

    // Ten PERFECTs, then the 11th doubles
    for (int n = 0; n < 10; n++) begin
      new_note(10'd380);
      key_pulse(h);
    end
    check("ten_score", bus_if.score, 1000);
    check("ten_combo", bus_if.combo, 10);
    new_note(10'd380);
    key_pulse(h);
    check("eleventh_score", bus_if.score, 1200);
    check("eleventh_combo", bus_if.combo, 11);

    // Window boundaries (bonus active)
    new_note(10'd388);
    key_pulse(h);
    check("d8_judge", bus_if.judge, JUDGE_PERFECT);
    check("d8_score", bus_if.score, 1400);
    new_note(10'd389);
    key_pulse(h);
    check("d9_judge", bus_if.judge, JUDGE_GOOD);
    check("d9_score", bus_if.score, 1500);
    new_note(10'd404);
    key_pulse(h);
    check("d24_judge", bus_if.judge, JUDGE_GOOD);
    check("d24_score", bus_if.score, 1600);
    check("d24_combo", bus_if.combo, 14);

    // Distance 25 above the line: ignored; then the note vanishes -> MISS
    hits0 = hit_cnt;
    miss0 = miss_cnt;
    new_note(10'd355);
    key_pulse(h);
    check("d25_nohit",  hit_cnt - hits0, 0);
    check("d25_score",  bus_if.score, 1600);
    bus_if.note_active = 1'b0;
    cycles(2);
    check("vanish_miss",  miss_cnt - miss0, 1);
    check("vanish_judge", bus_if.judge, JUDGE_MISS);
    check("vanish_combo", bus_if.combo, 0);
    new_note(10'd372);
    key_pulse(h);
    check("d8_above_judge", bus_if.judge, JUDGE_PERFECT);
    check("d8_above_score", bus_if.score, 1700);

    // Key held high across two notes
    hits0 = hit_cnt;
    miss0 = miss_cnt;
    new_note(10'd380);
    bus_if.key_press = 1'b1;
    cycles(6);
    check("held_first_score", bus_if.score, 1800);
    new_note(10'd380);
    cycles(6);
    ramp_to_miss(380, my);
    bus_if.key_press = 1'b0;
    check("held_hits",  hit_cnt - hits0, 1);
    check("held_miss",  miss_cnt - miss0, 1);
    check("held_combo", bus_if.combo, 0);
    check("held_judge", bus_if.judge, JUDGE_MISS);

    // Saturation: 330 PERFECTs from score 1800 overflow 16 bits and pass combo 255
    for (int n = 0; n < 330; n++) begin
      new_note(10'd380);
      key_pulse(h);
    end
    check("sat_score", bus_if.score, 16'hFFFF);
    check("sat_combo", bus_if.combo, 255);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
